texel_assembler_core: RTL and testbench

- Packs a stream of 32-bit words from the AHB read buffer into 168-bit (21-byte) texels for the texture pipeline.
- Sits between the AHB master read FIFO and the texel consumer.
- Byte stream is contiguous: leftover bytes of the last word of one texel become the first bytes of the next texel.
- Exactly one texel is held and presented at a time, with a ready/read handshake.

---
 rtl/texel_asm_pkg.sv | 31 +++
 rtl/texel_assembler_core_texel_byte_packer.sv | 52 +++++
 rtl/texel_assembler_core.sv | 52 +++++
 tb/tb_texel_assembler_core.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/texel_asm_pkg.sv
// Shared widths, types and helpers for the texel assembler.
// Optional build macro TEXEL_ASM_BSWAP_EN selects big-endian word packing.
package texel_asm_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int TEXEL_BYTES = 21;
  localparam int TEXEL_W     = 8 * TEXEL_BYTES;
  localparam int WORD_W      = 8 * WORD_BYTES;
  localparam int ACC_BYTES   = 24;
  localparam int ACC_W       = 8 * ACC_BYTES;
  localparam int CNT_W       = 5;

  typedef logic [TEXEL_W-1:0] texel_t;
  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [ACC_W-1:0]   acc_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  // One request per cycle into the packer; push and shift are never both set.
  typedef struct packed {
    logic  push;
    logic  shift;
    word_t word;
  } pack_req_t;

  function automatic word_t bswap(input word_t w);
    word_t r;
    for (int j = 0; j < WORD_BYTES; j++) r[j*8 +: 8] = w[(WORD_BYTES-1-j)*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/texel_assembler_core_texel_byte_packer.sv
// Byte accumulator: appends words at the current fill level and drops one
// texel's worth of bytes on a shift. TEXEL_ASM_BSWAP_EN reverses each word first.
module texel_byte_packer
  import texel_asm_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  pack_req_t req,
  output texel_t    texel,
  output cnt_t      cnt
);

  acc_t  acc_q, acc_d;
  cnt_t  cnt_q, cnt_d;
  word_t word_in;

`ifdef TEXEL_ASM_BSWAP_EN
  assign word_in = bswap(req.word);
`else
  assign word_in = req.word;
`endif

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (req.shift) begin
      // Leftover bytes slide to byte 0; vacated top bytes become zero.
      acc_d = acc_q >> TEXEL_W;
      cnt_d = cnt_q - cnt_t'(TEXEL_BYTES);
    end else if (req.push) begin
      for (int j = 0; j < WORD_BYTES; j++) begin
        if (int'(cnt_q) + j < ACC_BYTES)
          acc_d[(int'(cnt_q) + j)*8 +: 8] = word_in[j*8 +: 8];
      end
      cnt_d = cnt_q + cnt_t'(WORD_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign texel = acc_q[TEXEL_W-1:0];
  assign cnt   = cnt_q;

endmodule

// File: rtl/texel_assembler_core.sv
// Packs 32-bit AHB read-buffer words into 21-byte texels with a ready/read handshake.
// Build macro TEXEL_ASM_BSWAP_EN (in the packer) selects big-endian word order.
module texel_assembler_core
  import texel_asm_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic [WORD_W-1:0]  ahb_buffer,
  input  logic               ahb_data_available,
  input  logic               texel_read,
  output logic               ahb_user_read_buffer,
  output logic [TEXEL_W-1:0] texel_buffer,
  output logic               texel_ready
);

  cnt_t      cnt;
  texel_t    texel;
  pack_req_t req;
  logic      rdy_q, rdy_d;
  logic      rd, consume;

  // Fetch stops while a texel is presented, so accept and consume never coincide.
  assign rd      = ahb_data_available & ~rdy_q & (cnt < cnt_t'(TEXEL_BYTES)) & ~n_rst;
  assign consume = rdy_q & texel_read;
  assign req     = '{push: rd, shift: consume, word: ahb_buffer};

  texel_byte_packer u_packer (
    .clk   (clk),
    .rst   (n_rst),
    .req   (req),
    .texel (texel),
    .cnt   (cnt)
  );

  always_comb begin
    rdy_d = rdy_q;
    if (consume)
      rdy_d = 1'b0;
    else if (rd && (cnt + cnt_t'(WORD_BYTES) >= cnt_t'(TEXEL_BYTES)))
      rdy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (n_rst) rdy_q <= 1'b0;
    else       rdy_q <= rdy_d;
  end

  assign ahb_user_read_buffer = rd;
  assign texel_buffer         = texel;
  assign texel_ready          = rdy_q;

endmodule

// File: tb/tb_texel_assembler_core.sv
// Scoreboard bench: a byte-stream model predicts strobe/ready each cycle and
// queues expected texels, which are compared when the bench consumes them.
module tb_texel_assembler_core;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [31:0]  ahb_buffer;
  logic         ahb_data_available;
  logic         texel_read;
  logic         ahb_user_read_buffer;
  logic [167:0] texel_buffer;
  logic         texel_ready;

  texel_assembler_core dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .ahb_buffer           (ahb_buffer),
    .ahb_data_available   (ahb_data_available),
    .texel_read           (texel_read),
    .ahb_user_read_buffer (ahb_user_read_buffer),
    .texel_buffer         (texel_buffer),
    .texel_ready          (texel_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0]  stim_q[$];
  logic [7:0]   m_bytes[$];
  logic [167:0] exp_q[$];
  int           m_cnt = 0;
  logic         m_ready = 1'b0;
  logic         stall = 1'b0;

  task automatic chk(input string tag, input logic [167:0] got, input logic [167:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive();
    ahb_buffer         = (stim_q.size() > 0) ? stim_q[0] : 32'h0;
    ahb_data_available = !stall && (stim_q.size() > 0);
  endtask

  // One clock: check outputs against the model, then advance model and stimulus.
  task automatic cycle();
    logic         exp_rd;
    logic [167:0] t;
    @(negedge clk);
    exp_rd = ahb_data_available && !m_ready && (m_cnt < 21) && !n_rst;
    chk("rd_strobe", ahb_user_read_buffer, exp_rd);
    chk("texel_ready", texel_ready, m_ready);
    if (m_ready && texel_read && !n_rst) begin
      if (exp_q.size() > 0) chk("texel", texel_buffer, exp_q.pop_front());
      else chk("sb_underflow", 1, 0);
    end
    @(posedge clk);
    if (n_rst) begin
      m_bytes.delete();
      m_cnt = 0;
      m_ready = 1'b0;
    end else if (exp_rd) begin
`ifdef TEXEL_ASM_BSWAP_EN
      for (int j = 3; j >= 0; j--) m_bytes.push_back(ahb_buffer[j*8 +: 8]);
`else
      for (int j = 0; j < 4; j++) m_bytes.push_back(ahb_buffer[j*8 +: 8]);
`endif
      void'(stim_q.pop_front());
      m_cnt += 4;
      if (m_cnt >= 21) begin
        m_ready = 1'b1;
        for (int b = 0; b < 21; b++) t[b*8 +: 8] = m_bytes[b];
        exp_q.push_back(t);
      end
    end else if (m_ready && texel_read) begin
      m_ready = 1'b0;
      m_cnt -= 21;
      repeat (21) void'(m_bytes.pop_front());
    end
    #1;
    drive();
  endtask

  task automatic wait_ready(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      cycle();
      if (texel_ready === 1'b1) break;
    end
    if (i == max_cyc) chk("ready_timeout", 0, 1);
  endtask

  task automatic consume();
    texel_read = 1'b1;
    cycle();
    texel_read = 1'b0;
  endtask

  logic [167:0] exp_basic, exp_carry, held;

  initial begin
    n_rst = 1'b1;
    texel_read = 1'b0;
    stim_q = '{32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC,
               32'h76543210, 32'hFEDBCA98};
    drive();
    repeat (2) @(posedge clk);
    #1;
    // Reset held with data available: no strobe, no texel, zero output.
    cycle();
    cycle();
    chk("reset_texel", texel_buffer, 168'h0);
    n_rst = 1'b0;
    drive();

    // Basic texel
    wait_ready(20);
    exp_basic = 168'h98_76543210_FFEEDDCC_BBAA9988_77665544_33221100;
`ifdef TEXEL_ASM_BSWAP_EN
    chk("bswap_low_word", texel_buffer[31:0], 32'h00112233);
`else
    chk("basic_texel", texel_buffer, exp_basic);
`endif
    held = texel_buffer;

    // Hold with no read
    repeat (5) cycle();
    chk("hold_stable", texel_buffer, held);

    // Consume and carry the 3 leftover bytes
    stim_q = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 32'h13121110};
    drive();
    consume();
    wait_ready(20);
`ifndef TEXEL_ASM_BSWAP_EN
    exp_carry[7:0] = 8'hCA;
    exp_carry[15:8] = 8'hDB;
    exp_carry[23:16] = 8'hFE;
    for (int b = 3; b < 21; b++) exp_carry[b*8 +: 8] = 8'(b - 3);
    chk("carry_texel", texel_buffer, exp_carry);
    chk("carry_top_byte", texel_buffer[167:160], 8'h11);
`endif

    // Stall mid-texel
    for (int i = 0; i < 5; i++) stim_q.push_back(32'hA0B0C0D0 ^ (32'h01010101 * i));
    drive();
    consume();
    repeat (2) cycle();
    stall = 1'b1;
    drive();
    repeat (3) cycle();
    stall = 1'b0;
    drive();
    wait_ready(20);
    consume();

    // Spurious read while not ready
    stall = 1'b1;
    for (int i = 0; i < 6; i++) stim_q.push_back(32'h5A5A0000 + 32'(i));
    drive();
    texel_read = 1'b1;
    repeat (2) cycle();
    texel_read = 1'b0;
    stall = 1'b0;
    drive();
    wait_ready(20);
    consume();

    // Random stream with random stalls
    for (int i = 0; i < 24; i++) stim_q.push_back($urandom);
    drive();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 30 && texel_ready !== 1'b1; c++) begin
        stall = ($urandom_range(0, 3) == 0);
        drive();
        cycle();
      end
      stall = 1'b0;
      drive();
      wait_ready(20);
      consume();
    end

    // Reset mid-assembly discards the partial texel
    stim_q.delete();
    for (int i = 0; i < 3; i++) stim_q.push_back(32'hDEAD0000 + 32'(i));
    drive();
    repeat (3) cycle();
    n_rst = 1'b1;
    cycle();
    n_rst = 1'b0;
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(32'hC0DE0000 + 32'(i));
    drive();
    wait_ready(20);
    chk("post_reset_byte0", texel_buffer[7:0], 8'h00);
    consume();
    chk("sb_empty", 168'(exp_q.size()), 168'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
